// File: rtl/ttl_pkg.sv
// Shared helpers for the ttl_* register/queue blocks: pointer sizing and
// the COUNT width rule (one bit wider than a pointer so 0..DEPTH fits).
package ttl_pkg;

   localparam int CNT_EXTRA_BITS = 1;

   function automatic int clog2(input int v);
      int r;
      int x;
      r = 0;
      x = (v > 0) ? v - 1 : 0;
      while (x != 0) begin
         r = r + 1;
         x = x >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/ttl_reg_fifo_mem.sv
// DEPTH x WIDTH register array: one clocked write port, one async read port.
// No reset on the storage; readers must qualify contents with occupancy.
module ttl_reg_fifo_mem #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic             i_clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ttl_reg_fifo.sv
// FWFT queue with registered head (Q, 1-cycle push-to-Q) and 3-state Y bus.
// Push while full is dropped (OVF), pop while empty is ignored (UNF); both sticky.
module ttl_reg_fifo
   import ttl_pkg::*;
#(
   parameter  int WIDTH = 4,
   parameter  int DEPTH = 4,
   localparam int AW    = clog2(DEPTH),
   localparam int CW    = AW + CNT_EXTRA_BITS
) (
   input  logic             CK,
   input  logic             RESET_n,
   input  logic             CLR_n,
   input  logic [WIDTH-1:0] D,
   input  logic             WE_n,
   input  logic             RE_n,
   input  logic             OE_n,
   output logic [WIDTH-1:0] Q,
   inout  wire  [WIDTH-1:0] Y,
   output logic [CW-1:0]    COUNT,
   output logic             EMPTY,
   output logic             FULL,
   output logic             OVF,
   output logic             UNF
);

   logic [AW-1:0]    r_wp;
   logic [AW-1:0]    r_rp;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_q;
   logic             r_ovf;
   logic             r_unf;

   logic             w_push;
   logic             w_pop;
   logic             w_do_push;
   logic             w_do_pop;
   logic [AW-1:0]    w_rp_nxt;
   logic [CW-1:0]    w_count_nxt;
   logic [WIDTH-1:0] w_rdata;
   logic [WIDTH-1:0] w_q_nxt;

   assign w_push    = ~WE_n;
   assign w_pop     = ~RE_n;
   assign EMPTY     = (r_count == '0);
   assign FULL      = (r_count == CW'(DEPTH));
   assign w_do_pop  = w_pop & ~EMPTY;
   // A pop at the same edge frees a slot, so a full queue still accepts the push.
   assign w_do_push = w_push & (~FULL | w_do_pop);

   assign w_rp_nxt    = w_do_pop ? r_rp + AW'(1) : r_rp;
   assign w_count_nxt = r_count + CW'(w_do_push) - CW'(w_do_pop);

   ttl_reg_fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .i_clk   (CK),
      .i_we    (w_do_push & CLR_n),
      .i_waddr (r_wp),
      .i_wdata (D),
      .i_raddr (w_rp_nxt),
      .o_rdata (w_rdata)
   );

   // The next head is the word being written this edge when it lands in the head slot.
   always_comb begin
      w_q_nxt = '0;
      if (w_count_nxt != '0) begin
         w_q_nxt = (w_do_push && (w_rp_nxt == r_wp)) ? D : w_rdata;
      end
   end

   always_ff @(posedge CK or negedge RESET_n) begin
      if (!RESET_n) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
         r_q     <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else if (!CLR_n) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
         r_q     <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else begin
         if (w_do_push) r_wp <= r_wp + AW'(1);
         r_rp    <= w_rp_nxt;
         r_count <= w_count_nxt;
         r_q     <= w_q_nxt;
         if (w_push && !w_do_push) r_ovf <= 1'b1;
         if (w_pop && EMPTY)       r_unf <= 1'b1;
      end
   end

   assign Q     = r_q;
   assign COUNT = r_count;
   assign OVF   = r_ovf;
   assign UNF   = r_unf;
   assign Y     = OE_n ? {WIDTH{1'bz}} : r_q;

endmodule

// File: tb/tb_ttl_reg_fifo.sv
// Drives a 4x4 and an 8x8 instance with identical controls and checks both
// against queue-based reference models of the queue rules.
module tb_ttl_reg_fifo;

   logic       CK = 1'b0;
   logic       RESET_n;
   logic       CLR_n;
   logic       WE_n;
   logic       RE_n;
   logic       OE_n;
   logic [3:0] D4;
   logic [7:0] D8;

   logic [3:0] Q4;
   logic [2:0] COUNT4;
   logic       EMPTY4, FULL4, OVF4, UNF4;
   wire  [3:0] Y4;

   logic [7:0] Q8;
   logic [3:0] COUNT8;
   logic       EMPTY8, FULL8, OVF8, UNF8;
   wire  [7:0] Y8;

   logic       drv_en;
   logic [7:0] drv_pat;

   int n_assert = 0;
   int n_fail   = 0;

   int q4[$];
   int q8[$];
   bit ovf4, unf4, ovf8, unf8;

   assign Y4 = drv_en ? drv_pat[3:0] : 4'bzzzz;
   assign Y8 = drv_en ? drv_pat : 8'bzzzzzzzz;

   always #5 CK = ~CK;

   ttl_reg_fifo #(.WIDTH(4), .DEPTH(4)) u_dut4 (
      .CK(CK), .RESET_n(RESET_n), .CLR_n(CLR_n), .D(D4), .WE_n(WE_n), .RE_n(RE_n),
      .OE_n(OE_n), .Q(Q4), .Y(Y4), .COUNT(COUNT4), .EMPTY(EMPTY4), .FULL(FULL4),
      .OVF(OVF4), .UNF(UNF4)
   );

   ttl_reg_fifo #(.WIDTH(8), .DEPTH(8)) u_dut8 (
      .CK(CK), .RESET_n(RESET_n), .CLR_n(CLR_n), .D(D8), .WE_n(WE_n), .RE_n(RE_n),
      .OE_n(OE_n), .Q(Q8), .Y(Y8), .COUNT(COUNT8), .EMPTY(EMPTY8), .FULL(FULL8),
      .OVF(OVF8), .UNF(UNF8)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int head4();
      return (q4.size() != 0) ? q4[0] : 0;
   endfunction

   function automatic int head8();
      return (q8.size() != 0) ? q8[0] : 0;
   endfunction

   task automatic model_clear();
      q4.delete();
      q8.delete();
      ovf4 = 1'b0; unf4 = 1'b0;
      ovf8 = 1'b0; unf8 = 1'b0;
   endtask

   task automatic model_edge(input bit we_n, input bit re_n, input bit clr_n, input logic [7:0] d);
      bit push;
      bit pop;
      bit popok;
      bit pushok;
      push = !we_n;
      pop  = !re_n;
      if (!clr_n) begin
         model_clear();
      end else begin
         popok  = pop && (q4.size() > 0);
         pushok = push && ((q4.size() < 4) || popok);
         if (pop && q4.size() == 0) unf4 = 1'b1;
         if (push && !pushok) ovf4 = 1'b1;
         if (popok) void'(q4.pop_front());
         if (pushok) q4.push_back(int'(d[3:0]));

         popok  = pop && (q8.size() > 0);
         pushok = push && ((q8.size() < 8) || popok);
         if (pop && q8.size() == 0) unf8 = 1'b1;
         if (push && !pushok) ovf8 = 1'b1;
         if (popok) void'(q8.pop_front());
         if (pushok) q8.push_back(int'(d));
      end
   endtask

   task automatic check_all();
      chk("q4",     32'(Q4),     32'(head4()));
      chk("count4", 32'(COUNT4), 32'(q4.size()));
      chk("empty4", 32'(EMPTY4), 32'(q4.size() == 0));
      chk("full4",  32'(FULL4),  32'(q4.size() == 4));
      chk("ovf4",   32'(OVF4),   32'(ovf4));
      chk("unf4",   32'(UNF4),   32'(unf4));
      chk("q8",     32'(Q8),     32'(head8()));
      chk("count8", 32'(COUNT8), 32'(q8.size()));
      chk("empty8", 32'(EMPTY8), 32'(q8.size() == 0));
      chk("full8",  32'(FULL8),  32'(q8.size() == 8));
      chk("ovf8",   32'(OVF8),   32'(ovf8));
      chk("unf8",   32'(UNF8),   32'(unf8));
      if (OE_n == 1'b0) begin
         chk("y4_drive", 32'(Y4), 32'(head4()));
         chk("y8_drive", 32'(Y8), 32'(head8()));
      end
   endtask

   task automatic step(input bit we_n, input bit re_n, input bit clr_n, input bit oe_n,
                       input logic [7:0] d);
      WE_n  = we_n;
      RE_n  = re_n;
      CLR_n = clr_n;
      OE_n  = oe_n;
      D4    = d[3:0];
      D8    = d;
      @(posedge CK);
      #1;
      model_edge(we_n, re_n, clr_n, d);
      check_all();
   endtask

   task automatic bus_hiz(input logic [7:0] pat);
      OE_n    = 1'b1;
      drv_pat = pat;
      drv_en  = 1'b1;
      #1;
      chk("y4_hiz", 32'(Y4), 32'(pat[3:0]));
      chk("y8_hiz", 32'(Y8), 32'(pat));
      drv_en = 1'b0;
      #1;
   endtask

   task automatic async_reset();
      #2;
      RESET_n = 1'b0;
      #1;
      model_clear();
      check_all();
      #2;
      RESET_n = 1'b1;
   endtask

   initial begin
      RESET_n = 1'b0;
      CLR_n   = 1'b1;
      WE_n    = 1'b1;
      RE_n    = 1'b1;
      OE_n    = 1'b1;
      D4      = '0;
      D8      = '0;
      drv_en  = 1'b0;
      drv_pat = '0;
      model_clear();

      // Reset state, no clock edge needed
      #3;
      check_all();
      #4;
      RESET_n = 1'b1;

      // Fill then drain
      for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 8'(i));
      chk("fill_full",  32'(FULL4),  32'd1);
      chk("fill_count", 32'(COUNT4), 32'd4);
      chk("fill_q",     32'(Q4),     32'd1);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
      chk("drain4_empty", 32'(EMPTY4), 32'd1);
      chk("drain4_q",     32'(Q4),     32'd0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 8'h00);

      // Full push+pop, then drain across the pointer wrap
      step(1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
      for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 8'(i));
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'h05);
      chk("fullpp_q",     32'(Q4),     32'd2);
      chk("fullpp_count", 32'(COUNT4), 32'd4);
      for (int i = 0; i < 4; i++) begin
         chk("wrap_head", 32'(Q4), 32'(i + 2));
         step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
      end

      // Overflow and underflow, then synchronous clear
      step(1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
      for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 8'(i));
      step(1'b0, 1'b1, 1'b1, 1'b1, 8'h09);
      chk("ovf_set", 32'(OVF4), 32'd1);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
      chk("unf_set", 32'(UNF4), 32'd1);
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      chk("clr_ovf",   32'(OVF4),   32'd0);
      chk("clr_unf",   32'(UNF4),   32'd0);
      chk("clr_count", 32'(COUNT4), 32'd0);

      // Push+pop on empty: push wins, UNF flags the ignored pop
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'h0A);
      chk("emptypp_q",     32'(Q4),     32'hA);
      chk("emptypp_count", 32'(COUNT4), 32'd1);
      chk("emptypp_unf",   32'(UNF4),   32'd1);

      // Bus: released when disabled, follows Q immediately when enabled
      step(1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
      step(1'b0, 1'b1, 1'b1, 1'b1, 8'h06);
      bus_hiz(8'hA5);
      bus_hiz(8'h5A);
      bus_hiz(8'h00);
      OE_n = 1'b0;
      #1;
      chk("y4_q6", 32'(Y4), 32'b0110);
      chk("y8_q6", 32'(Y8), 32'h06);

      // Eight pushes fill the 8x8 instance exactly
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 8'(8'h30 + i));
      chk("w8_notfull7", 32'(FULL8), 32'd0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 8'h37);
      chk("w8_full",  32'(FULL8),  32'd1);
      chk("w8_count", 32'(COUNT8), 32'd8);

      // Async reset mid-transfer, then normal operation on the next edge
      async_reset();
      step(1'b0, 1'b1, 1'b1, 1'b0, 8'hC3);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 23) != 0), 1'($urandom_range(0, 1)),
              8'($urandom_range(0, 255)));
         if (i == 200) begin
            async_reset();
         end
         if ((i % 50) == 25) begin
            bus_hiz(8'($urandom_range(0, 255)));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
